// File: rtl/ctrl_fsm_rv32i.sv
// Multi-cycle RV32I control sequencer. Datapath strobes are decoded combinationally
// from the state register and the IR, with a ready-based memory handshake and bus-timeout trap.
module ctrl_fsm_rv32i #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT     = 200,
  parameter bit HALT_ON_SYS = 1'b1,
  parameter bit X0_SUPPRESS = 1'b1
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst_n,
  input  logic [31:0] instr_in,
  input  logic        bc_in,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        addr_sel,
  output logic        ir_wr_en,
  output logic        mar_wr_en,
  output logic        reg_wr_en,
  output logic        bc_en,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  imm_type,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP} state_t;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYSTEM = 7'h73;
  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_XOR = 4'd3, ALU_OR = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9, ALU_SLTU = 4'd10;
  localparam logic [TIMEOUT_W:0] TO_LIM = (TIMEOUT_W + 1)'(TIMEOUT);

  state_t                 state, state_nxt;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  logic [TIMEOUT_W:0]     wait_inc;
  logic                   wait_hit;
  logic [1:0]             trap_cause_r, cause_nxt;
  logic [6:0]             opcode, funct7;
  logic [2:0]             funct3, imm_dec;
  logic [4:0]             rd;
  logic                   legal;
  logic [3:0]             alu_dec;

  logic mem_req_c, mem_we_c, mem_uns_c, addr_sel_c, ir_wr_c, mar_wr_c, reg_wr_c;
  logic bc_en_c, pc_inc_c, pc_load_c, alu_a_c, alu_b_c;
  logic [1:0] mem_size_c, pc_src_c, wb_sel_c;
  logic [3:0] alu_op_c;

  assign opcode = instr_in[6:0];
  assign rd     = instr_in[11:7];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  // The timeout fires on the wait cycle that would bring the count up to TIMEOUT.
  assign wait_inc = {1'b0, wait_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign wait_hit = (wait_inc >= TO_LIM);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, OP_FENCE: legal = 1'b1;
      OP_JALR:   legal = (funct3 == 3'd0);
      OP_BRANCH: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      OP_LOAD:   legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      OP_STORE:  legal = (funct3 <= 3'd2);
      OP_IMM: begin
        case (funct3)
          3'd1:    legal = (funct7 == 7'h00);
          3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OP_REG:    legal = (funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      default:   legal = 1'b0;
    endcase
  end

  // funct7[5] selects sub only for register-register ops; for OP-IMM it is immediate data.
  always_comb begin
    alu_dec = ALU_NONE;
    case (funct3)
      3'd0: alu_dec = ((opcode == OP_REG) && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'd1: alu_dec = ALU_SLL;
      3'd2: alu_dec = ALU_SLT;
      3'd3: alu_dec = ALU_SLTU;
      3'd4: alu_dec = ALU_XOR;
      3'd5: alu_dec = funct7[5] ? ALU_SRA : ALU_SRL;
      3'd6: alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    imm_dec = 3'd0;
    case (opcode)
      OP_STORE:         imm_dec = 3'd1;
      OP_BRANCH:        imm_dec = 3'd2;
      OP_LUI, OP_AUIPC: imm_dec = 3'd3;
      OP_JAL:           imm_dec = 3'd4;
      default:          imm_dec = 3'd0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cause_nxt  = 2'd0;
    mem_req_c  = 1'b0; mem_we_c  = 1'b0; mem_size_c = 2'd0; mem_uns_c = 1'b0; addr_sel_c = 1'b0;
    ir_wr_c    = 1'b0; mar_wr_c  = 1'b0; reg_wr_c   = 1'b0; bc_en_c   = 1'b0;
    pc_inc_c   = 1'b0; pc_load_c = 1'b0; pc_src_c   = 2'd0; wb_sel_c  = 2'd0;
    alu_a_c    = 1'b0; alu_b_c   = 1'b0; alu_op_c   = ALU_NONE;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        mem_size_c = 2'd2;
        if (mem_ready) begin
          ir_wr_c   = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd2;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd1;
        end else if (opcode == OP_SYSTEM) begin
          if (HALT_ON_SYS) state_nxt = S_HALT;
          else begin
            pc_inc_c  = 1'b1;
            state_nxt = S_FETCH;
          end
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_REG, OP_IMM: begin
            alu_op_c = alu_dec; alu_b_c = (opcode == OP_IMM); reg_wr_c = 1'b1; pc_inc_c = 1'b1;
          end
          OP_LUI:   begin wb_sel_c = 2'd3; reg_wr_c = 1'b1; pc_inc_c = 1'b1; end
          OP_AUIPC: begin
            alu_a_c = 1'b1; alu_b_c = 1'b1; alu_op_c = ALU_ADD; reg_wr_c = 1'b1; pc_inc_c = 1'b1;
          end
          OP_JAL:   begin wb_sel_c = 2'd2; reg_wr_c = 1'b1; pc_load_c = 1'b1; end
          OP_JALR:  begin
            alu_op_c = ALU_ADD; alu_b_c = 1'b1; wb_sel_c = 2'd2; reg_wr_c = 1'b1;
            pc_load_c = 1'b1; pc_src_c = 2'd1;
          end
          OP_BRANCH: begin
            bc_en_c = 1'b1;
            if (bc_in) pc_load_c = 1'b1;
            else       pc_inc_c  = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            alu_op_c = ALU_ADD; alu_b_c = 1'b1; mar_wr_c = 1'b1; state_nxt = S_MEM;
          end
          default:  pc_inc_c = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = (opcode == OP_STORE);
        mem_size_c = funct3[1:0];
        mem_uns_c  = (opcode == OP_LOAD) && funct3[2];
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_inc_c  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd2;
        end
      end
      S_WB: begin
        wb_sel_c = 2'd1; reg_wr_c = 1'b1; pc_inc_c = 1'b1; state_nxt = S_FETCH;
      end
      default: state_nxt = state;
    endcase
    if (X0_SUPPRESS && (rd == 5'd0)) reg_wr_c = 1'b0;
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      trap_cause_r <= 2'd0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || mem_ready) wait_cnt <= '0;
      else if (mem_req_c)                    wait_cnt <= wait_inc[TIMEOUT_W-1:0];
      if ((state_nxt == S_TRAP) && (state != S_TRAP)) trap_cause_r <= cause_nxt;
    end
  end

  // Outputs are held at zero while reset is asserted, even though the state already reads FETCH.
  assign mem_req      = ctrl_rst_n & mem_req_c;
  assign mem_we       = ctrl_rst_n & mem_we_c;
  assign mem_size     = ctrl_rst_n ? mem_size_c : 2'd0;
  assign mem_unsigned = ctrl_rst_n & mem_uns_c;
  assign addr_sel     = ctrl_rst_n & addr_sel_c;
  assign ir_wr_en     = ctrl_rst_n & ir_wr_c;
  assign mar_wr_en    = ctrl_rst_n & mar_wr_c;
  assign reg_wr_en    = ctrl_rst_n & reg_wr_c;
  assign bc_en        = ctrl_rst_n & bc_en_c;
  assign pc_inc       = ctrl_rst_n & pc_inc_c;
  assign pc_load      = ctrl_rst_n & pc_load_c;
  assign pc_src       = ctrl_rst_n ? pc_src_c : 2'd0;
  assign wb_sel       = ctrl_rst_n ? wb_sel_c : 2'd0;
  assign alu_a_sel    = ctrl_rst_n & alu_a_c;
  assign alu_b_sel    = ctrl_rst_n & alu_b_c;
  assign alu_opcode   = ctrl_rst_n ? alu_op_c : ALU_NONE;
  assign imm_type     = ctrl_rst_n ? imm_dec : 3'd0;
  assign halted       = ctrl_rst_n & (state == S_HALT);
  assign trap         = ctrl_rst_n & (state == S_TRAP);
  assign trap_cause   = ctrl_rst_n ? trap_cause_r : 2'd0;

endmodule

// File: tb/tb_ctrl_fsm_rv32i.sv
// Bench for ctrl_fsm_rv32i: each driven cycle pushes the expected output vector to a
// scoreboard queue, which a monitor pops and compares mid-way through the low clock phase.
module tb_ctrl_fsm_rv32i;

  typedef struct packed {
    logic       mem_req;   logic       mem_we;    logic [1:0] mem_size;  logic mem_unsigned;
    logic       addr_sel;  logic       ir_wr_en;  logic       mar_wr_en; logic reg_wr_en;
    logic       bc_en;     logic       pc_inc;    logic       pc_load;   logic [1:0] pc_src;
    logic [1:0] wb_sel;    logic       alu_a_sel; logic       alu_b_sel; logic [3:0] alu_opcode;
    logic [2:0] imm_type;  logic       halted;    logic       trap;      logic [1:0] trap_cause;
  } ov_t;

  typedef struct {
    string tag;
    ov_t   e;
  } sb_t;

  localparam logic [31:0] I_ADDI = 32'h00500093, I_LW  = 32'h0040A103, I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_ADD0 = 32'h00208033, I_SUB = 32'h402081B3, I_JALR = 32'h000280E7;
  localparam logic [31:0] I_JAL  = 32'h010000EF, I_LUI = 32'h123452B7, I_SW   = 32'h0020A423;
  localparam logic [31:0] I_LBU  = 32'h0000C183, I_BAD = 32'h0000007F, I_XORN = 32'h4020C1B3;
  localparam logic [31:0] I_ECALL = 32'h00000073, I_LD3 = 32'h0000B183;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst_n, bc_in, mem_ready;
  logic [31:0] instr_in;
  logic        mem_req, mem_we, mem_unsigned, addr_sel, ir_wr_en, mar_wr_en, reg_wr_en;
  logic        bc_en, pc_inc, pc_load, alu_a_sel, alu_b_sel, halted, trap;
  logic [1:0]  mem_size, pc_src, wb_sel, trap_cause;
  logic [3:0]  alu_opcode;
  logic [2:0]  imm_type;

  ov_t obs;
  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 ctrl_clk = ~ctrl_clk;

  ctrl_fsm_rv32i #(.TIMEOUT_W(8), .TIMEOUT(4), .HALT_ON_SYS(1'b1), .X0_SUPPRESS(1'b1)) dut (
    .ctrl_clk(ctrl_clk), .ctrl_rst_n(ctrl_rst_n), .instr_in(instr_in), .bc_in(bc_in),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr_sel(addr_sel), .ir_wr_en(ir_wr_en),
    .mar_wr_en(mar_wr_en), .reg_wr_en(reg_wr_en), .bc_en(bc_en), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_src(pc_src), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_opcode(alu_opcode), .imm_type(imm_type), .halted(halted),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign obs = {mem_req, mem_we, mem_size, mem_unsigned, addr_sel, ir_wr_en, mar_wr_en,
                reg_wr_en, bc_en, pc_inc, pc_load, pc_src, wb_sel, alu_a_sel, alu_b_sel,
                alu_opcode, imm_type, halted, trap, trap_cause};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ov_t vi(input logic [2:0] it);
    ov_t v;
    v = '0;
    v.imm_type = it;
    return v;
  endfunction

  function automatic ov_t vf(input logic rdy, input logic [2:0] it);
    ov_t v;
    v = vi(it);
    v.mem_req = 1'b1; v.mem_size = 2'd2; v.ir_wr_en = rdy;
    return v;
  endfunction

  function automatic ov_t vm(input logic rdy, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [2:0] it);
    ov_t v;
    v = vi(it);
    v.mem_req = 1'b1; v.addr_sel = 1'b1; v.mem_we = we; v.mem_size = sz;
    v.mem_unsigned = uns; v.pc_inc = rdy & we;
    return v;
  endfunction

  function automatic ov_t vt(input logic [1:0] cause, input logic [2:0] it);
    ov_t v;
    v = vi(it);
    v.trap = 1'b1; v.trap_cause = cause;
    return v;
  endfunction

  function automatic ov_t vls(input logic [2:0] it);
    ov_t v;
    v = vi(it);
    v.mar_wr_en = 1'b1; v.alu_opcode = 4'd1; v.alu_b_sel = 1'b1;
    return v;
  endfunction

  function automatic ov_t vwb();
    ov_t v;
    v = vi(3'd0);
    v.wb_sel = 2'd1; v.reg_wr_en = 1'b1; v.pc_inc = 1'b1;
    return v;
  endfunction

  task automatic step(input string tag, input logic rstn, input logic [31:0] ir,
                      input logic rdy, input logic bc, input ov_t e);
    sb_t s;
    @(negedge ctrl_clk);
    ctrl_rst_n = rstn;
    instr_in   = ir;
    mem_ready  = rdy;
    bc_in      = bc;
    s.tag = tag;
    s.e   = e;
    sb.push_back(s);
  endtask

  always @(negedge ctrl_clk) begin
    sb_t s;
    #2;
    if (sb.size() > 0) begin
      s = sb.pop_front();
      check(s.tag, 32'(obs), 32'(s.e));
    end
  end

  initial begin
    ov_t e;
    ov_t z;
    z = '0;
    ctrl_rst_n = 1'b0; instr_in = I_ADDI; mem_ready = 1'b1; bc_in = 1'b0;

    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, I_ADDI, 1'b1, 1'b0, z);

    step("addi_f", 1'b1, I_ADDI, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("addi_d", 1'b1, I_ADDI, 1'b1, 1'b0, vi(3'd0));
    e = vi(3'd0); e.reg_wr_en = 1'b1; e.alu_opcode = 4'd1; e.alu_b_sel = 1'b1; e.pc_inc = 1'b1;
    step("addi_x", 1'b1, I_ADDI, 1'b1, 1'b0, e);

    step("lw_f", 1'b1, I_LW, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("lw_d", 1'b1, I_LW, 1'b0, 1'b0, vi(3'd0));
    step("lw_x", 1'b1, I_LW, 1'b0, 1'b0, vls(3'd0));
    step("lw_m0", 1'b1, I_LW, 1'b0, 1'b0, vm(1'b0, 1'b0, 2'd2, 1'b0, 3'd0));
    step("lw_m1", 1'b1, I_LW, 1'b0, 1'b0, vm(1'b0, 1'b0, 2'd2, 1'b0, 3'd0));
    step("lw_m2", 1'b1, I_LW, 1'b1, 1'b0, vm(1'b1, 1'b0, 2'd2, 1'b0, 3'd0));
    step("lw_wb", 1'b1, I_LW, 1'b1, 1'b0, vwb());

    for (int t = 0; t < 2; t++) begin
      step("beq_f", 1'b1, I_BEQ, 1'b1, 1'b0, vf(1'b1, 3'd2));
      step("beq_d", 1'b1, I_BEQ, 1'b1, 1'b0, vi(3'd2));
      e = vi(3'd2); e.bc_en = 1'b1;
      if (t == 0) e.pc_load = 1'b1;
      else        e.pc_inc  = 1'b1;
      step(t == 0 ? "beq_taken" : "beq_not_taken", 1'b1, I_BEQ, 1'b1, (t == 0), e);
    end

    step("add0_f", 1'b1, I_ADD0, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("add0_d", 1'b1, I_ADD0, 1'b1, 1'b0, vi(3'd0));
    e = vi(3'd0); e.alu_opcode = 4'd1; e.pc_inc = 1'b1;
    step("add0_x", 1'b1, I_ADD0, 1'b1, 1'b0, e);

    step("sub_f", 1'b1, I_SUB, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("sub_d", 1'b1, I_SUB, 1'b1, 1'b0, vi(3'd0));
    e = vi(3'd0); e.alu_opcode = 4'd2; e.reg_wr_en = 1'b1; e.pc_inc = 1'b1;
    step("sub_x", 1'b1, I_SUB, 1'b1, 1'b0, e);

    step("jalr_f", 1'b1, I_JALR, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("jalr_d", 1'b1, I_JALR, 1'b1, 1'b0, vi(3'd0));
    e = vi(3'd0); e.alu_opcode = 4'd1; e.alu_b_sel = 1'b1; e.wb_sel = 2'd2;
    e.reg_wr_en = 1'b1; e.pc_load = 1'b1; e.pc_src = 2'd1;
    step("jalr_x", 1'b1, I_JALR, 1'b1, 1'b0, e);

    step("jal_f", 1'b1, I_JAL, 1'b1, 1'b0, vf(1'b1, 3'd4));
    step("jal_d", 1'b1, I_JAL, 1'b1, 1'b0, vi(3'd4));
    e = vi(3'd4); e.wb_sel = 2'd2; e.reg_wr_en = 1'b1; e.pc_load = 1'b1;
    step("jal_x", 1'b1, I_JAL, 1'b1, 1'b0, e);

    step("lui_f", 1'b1, I_LUI, 1'b1, 1'b0, vf(1'b1, 3'd3));
    step("lui_d", 1'b1, I_LUI, 1'b1, 1'b0, vi(3'd3));
    e = vi(3'd3); e.wb_sel = 2'd3; e.reg_wr_en = 1'b1; e.pc_inc = 1'b1;
    step("lui_x", 1'b1, I_LUI, 1'b1, 1'b0, e);

    step("sw_f", 1'b1, I_SW, 1'b1, 1'b0, vf(1'b1, 3'd1));
    step("sw_d", 1'b1, I_SW, 1'b1, 1'b0, vi(3'd1));
    step("sw_x", 1'b1, I_SW, 1'b1, 1'b0, vls(3'd1));
    step("sw_m0", 1'b1, I_SW, 1'b0, 1'b0, vm(1'b0, 1'b1, 2'd2, 1'b0, 3'd1));
    step("sw_m1", 1'b1, I_SW, 1'b1, 1'b0, vm(1'b1, 1'b1, 2'd2, 1'b0, 3'd1));

    step("lbu_f", 1'b1, I_LBU, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("lbu_d", 1'b1, I_LBU, 1'b1, 1'b0, vi(3'd0));
    step("lbu_x", 1'b1, I_LBU, 1'b1, 1'b0, vls(3'd0));
    step("lbu_m", 1'b1, I_LBU, 1'b1, 1'b0, vm(1'b1, 1'b0, 2'd0, 1'b1, 3'd0));
    step("lbu_wb", 1'b1, I_LBU, 1'b1, 1'b0, vwb());

    for (int i = 0; i < 4; i++) step("fetch_wait", 1'b1, I_ADDI, 1'b0, 1'b0, vf(1'b0, 3'd0));
    step("fetch_timeout", 1'b1, I_ADDI, 1'b0, 1'b0, vt(2'd2, 3'd0));
    step("trap_absorb", 1'b1, I_ADDI, 1'b1, 1'b0, vt(2'd2, 3'd0));
    step("trap_rst", 1'b0, I_ADDI, 1'b0, 1'b0, z);

    for (int i = 0; i < 3; i++) step("fetch_wait4", 1'b1, I_ADDI, 1'b0, 1'b0, vf(1'b0, 3'd0));
    step("fetch_rdy4", 1'b1, I_ADDI, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("fetch_rdy4_d", 1'b1, I_ADDI, 1'b0, 1'b0, vi(3'd0));
    e = vi(3'd0); e.reg_wr_en = 1'b1; e.alu_opcode = 4'd1; e.alu_b_sel = 1'b1; e.pc_inc = 1'b1;
    step("fetch_rdy4_x", 1'b1, I_ADDI, 1'b0, 1'b0, e);

    step("bad_f", 1'b1, I_BAD, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("bad_d", 1'b1, I_BAD, 1'b1, 1'b0, vi(3'd0));
    for (int i = 0; i < 3; i++) step("bad_trap", 1'b1, I_BAD, 1'b1, 1'b1, vt(2'd1, 3'd0));
    step("bad_rst", 1'b0, I_BAD, 1'b1, 1'b0, z);

    step("xorn_f", 1'b1, I_XORN, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("xorn_d", 1'b1, I_XORN, 1'b1, 1'b0, vi(3'd0));
    step("xorn_trap", 1'b1, I_XORN, 1'b1, 1'b0, vt(2'd1, 3'd0));
    step("xorn_rst", 1'b0, I_XORN, 1'b1, 1'b0, z);

    step("ld3_f", 1'b1, I_LD3, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("ld3_d", 1'b1, I_LD3, 1'b1, 1'b0, vi(3'd0));
    step("ld3_trap", 1'b1, I_LD3, 1'b1, 1'b0, vt(2'd1, 3'd0));
    step("ld3_rst", 1'b0, I_LD3, 1'b1, 1'b0, z);

    step("ecall_f", 1'b1, I_ECALL, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("ecall_d", 1'b1, I_ECALL, 1'b1, 1'b0, vi(3'd0));
    e = vi(3'd0); e.halted = 1'b1;
    step("ecall_halt0", 1'b1, I_ECALL, 1'b1, 1'b0, e);
    step("ecall_halt1", 1'b1, I_ECALL, 1'b1, 1'b0, e);
    step("ecall_rst", 1'b0, I_ECALL, 1'b1, 1'b0, z);

    step("lwto_f", 1'b1, I_LW, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("lwto_d", 1'b1, I_LW, 1'b0, 1'b0, vi(3'd0));
    step("lwto_x", 1'b1, I_LW, 1'b0, 1'b0, vls(3'd0));
    for (int i = 0; i < 4; i++) step("lwto_m", 1'b1, I_LW, 1'b0, 1'b0, vm(1'b0, 1'b0, 2'd2, 1'b0, 3'd0));
    step("lwto_trap", 1'b1, I_LW, 1'b0, 1'b0, vt(2'd2, 3'd0));
    step("lwto_rst", 1'b0, I_LW, 1'b0, 1'b0, z);

    step("mid_f", 1'b1, I_ADDI, 1'b1, 1'b0, vf(1'b1, 3'd0));
    step("mid_d", 1'b1, I_ADDI, 1'b1, 1'b0, vi(3'd0));
    step("mid_rst", 1'b0, I_ADDI, 1'b1, 1'b0, z);
    step("mid_refetch", 1'b1, I_ADDI, 1'b0, 1'b0, vf(1'b0, 3'd0));

    @(negedge ctrl_clk);
    #5;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_rv32i.md
# ctrl_fsm_rv32i

Parametrised multi-cycle RV32I control sequencer driving the datapath: IR, PC, register file, ALU, immediate generator, branch comparator and MAR/MDR. It generalises the single-phase control FSM with a ready-based memory handshake for both fetch and data accesses, bus-timeout trapping, full U/J/JALR/branch sequencing, x0 write suppression, and a configurable EBREAK/ECALL mode. It sits between the instruction register output and every datapath enable.

## Interface
- TIMEOUT_W, 8: width of the memory-wait counter.
- TIMEOUT, 200: wait cycles without `mem_ready` before a bus-timeout trap; must be < 2^TIMEOUT_W and ≥ 1.
- HALT_ON_SYS, 1: 1 = ECALL/EBREAK enter HALT; 0 = treated as NOP.
- X0_SUPPRESS, 1: 1 = `reg_wr_en` is forced low when rd == 0.

- ctrl_clk  in  1  clock, rising edge
- ctrl_rst_n  in  1  asynchronous, active-low reset
- instr_in  in  32  IR contents
- bc_in  in  1  branch condition from the comparator, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_size  out  2  0 = byte, 1 = half, 2 = word
- mem_unsigned  out  1  zero-extend load (LBU/LHU)
- addr_sel  out  1  0 = PC, 1 = MAR drives the address
- ir_wr_en, mar_wr_en, reg_wr_en, bc_en, pc_inc, pc_load  out  1 each  datapath strobes
- pc_src  out  2  0 = PC+imm, 1 = ALU result with bit 0 cleared
- wb_sel  out  2  0 = ALU, 1 = MDR, 2 = PC+4, 3 = imm
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_opcode  out  4  1 add, 2 sub, 3 xor, 4 or, 5 and, 6 sll, 7 srl, 8 sra, 9 slt, 10 sltu, 0 none
- imm_type  out  3  0 I, 1 S, 2 B, 3 U, 4 J
- halted  out  1  in HALT
- trap  out  1  in TRAP
- trap_cause  out  2  1 = illegal instruction, 2 = bus timeout; registered

## Operation
- State register: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. Strobes are combinational from state and instr_in. Only the state, wait counter and trap_cause are registered.
- FETCH: mem_req = 1, addr_sel = 0, mem_we = 0. When mem_ready = 1: ir_wr_en = 1, go to DECODE. Otherwise stay.
- DECODE: no strobes.
  - Illegal opcode or funct3/funct7 (including load funct3 3/6/7, store funct3 > 2, R-type funct7 not 0x00/0x20, or 0x20 outside sub/sra): go to TRAP with cause 1.
  - SYSTEM: go to HALT if HALT_ON_SYS = 1; otherwise pc_inc and go to FETCH.
  - All other instructions: go to EXEC.
- EXEC:
  - R / OP-IMM: ALU op from funct3/funct7, alu_b_sel = (OP-IMM), wb_sel = 0, reg_wr_en, pc_inc, go to FETCH.
  - LUI: wb_sel = 3. AUIPC: alu_a_sel = 1, alu_b_sel = 1, add, wb_sel = 0. Both also assert reg_wr_en and pc_inc, then go to FETCH.
  - JAL: wb_sel = 2, reg_wr_en, pc_load, pc_src = 0, go to FETCH.
  - JALR: add rs1+imm, wb_sel = 2, reg_wr_en, pc_load, pc_src = 1, go to FETCH.
  - Branch: bc_en = 1. If bc_in = 1: pc_load with pc_src = 0; else pc_inc. Go to FETCH.
  - Load/store: add rs1+imm, alu_b_sel = 1, mar_wr_en, go to MEM.
- MEM: mem_req = 1, addr_sel = 1, mem_we = store, mem_size/mem_unsigned from funct3. On mem_ready, a load goes to WB; a store asserts pc_inc and goes to FETCH.
- WB: wb_sel = 1, reg_wr_en, pc_inc, go to FETCH.
- imm_type is driven from the opcode in all states.
- X0 suppression: if X0_SUPPRESS = 1 and instr_in[11:7] = 0, reg_wr_en = 0; all other strobes are unchanged.
- HALT and TRAP are absorbing; only reset leaves them. All strobes are 0 in both states.

## Timing
- Reset, asynchronous on ctrl_rst_n = 0:
  - state = FETCH, wait counter = 0, trap_cause = 0.
  - While reset is asserted, every output is 0, including mem_req.
  - mem_req first rises in the first cycle after deassertion.
- Latency with zero wait (mem_ready high in the request cycle): ALU/LUI/AUIPC/JAL/JALR/branch take 3 cycles, stores 4, loads 5. Each memory wait cycle adds 1.
- Handshake: mem_req, mem_we, mem_size and address selection stay stable until the cycle with mem_ready = 1. The transfer completes in that cycle. mem_ready outside FETCH/MEM is ignored.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each cycle that mem_req = 1 and mem_ready = 0.
  - When it reaches TIMEOUT with mem_ready still 0: next state is TRAP with cause 2.
  - mem_ready in the same cycle as the timeout wins, and the transfer completes.
- Reset mid-operation aborts immediately; no partial register or PC write follows.

## Test plan
- Reset held 3 cycles, released, instr ADDI x1,x0,5 with mem_ready = 1 -> mem_req in cycle 1; in cycle 3 reg_wr_en = 1, wb_sel = 0, alu_opcode = 1, alu_b_sel = 1, pc_inc = 1; then FETCH.
- LW x2,4(x1) with mem_ready delayed 2 cycles in MEM -> mar_wr_en in EXEC, mem_req held 3 cycles, then WB with reg_wr_en = 1, wb_sel = 1; total 7 cycles.
- BEQ, once with bc_in = 1 and once with bc_in = 0 -> pc_load = 1 with pc_src = 0 for the first; pc_inc = 1 with pc_load = 0 for the second.
- ADD x0,x1,x2 with X0_SUPPRESS = 1 -> reg_wr_en = 0 and pc_inc = 1. JALR x1,0(x5) -> reg_wr_en = 1, wb_sel = 2, pc_src = 1.
- Opcode 0x7F -> TRAP, trap = 1, trap_cause = 1, all strobes 0 until reset.
- TIMEOUT = 4 and mem_ready never asserted in FETCH -> TRAP with cause 2 after 4 wait cycles. Repeat with mem_ready in exactly the 4th cycle -> DECODE.
